// File: rtl/risc_pkg.sv
// Shared Simple-RISC definitions: opcode encodings used by both the ALU and the CPU decoder.
package risc_pkg;

  typedef enum logic [2:0] {
    OPC_HLT = 3'b000,
    OPC_SKZ = 3'b001,
    OPC_ADD = 3'b010,
    OPC_AND = 3'b011,
    OPC_XOR = 3'b100,
    OPC_LDA = 3'b101,
    OPC_STO = 3'b110,
    OPC_JMP = 3'b111
  } opcode_t;

  localparam int OPC_W = 3;

endpackage

// File: rtl/risc_alu_core.sv
// Combinational accumulator ALU: computes the next accumulator value and its zero flag.
module risc_alu_core
  import risc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic [WIDTH-1:0] next_result,
  output logic             next_zero
);

  // Modular add: the carry out of the top bit is dropped.
  function automatic logic [WIDTH-1:0] add_wrap(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] w_res;

  always_comb begin
    w_res = inA;
    case (opcode)
      OPC_ADD: w_res = add_wrap(inA, inB);
      OPC_AND: w_res = inA & inB;
      OPC_XOR: w_res = inA ^ inB;
      OPC_LDA: w_res = inB;
      default: w_res = inA;
    endcase
  end

  assign next_result = w_res;
  assign next_zero   = (w_res == '0);

endmodule

// File: rtl/risc_alu.sv
// Registered accumulator ALU: one-cycle latency, result and zero flag updated on the same edge.
module risc_alu
  import risc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [OPC_W-1:0] opcode,
  output logic [WIDTH-1:0] result,
  output logic             is_zero
);

  logic [WIDTH-1:0] w_next_result_p0;
  logic             w_next_zero_p0;
  logic [WIDTH-1:0] r_result_p1;
  logic             r_zero_p1;

  risc_alu_core #(.WIDTH(WIDTH)) u_core (
    .opcode      (opcode),
    .inA         (inA),
    .inB         (inB),
    .next_result (w_next_result_p0),
    .next_zero   (w_next_zero_p0)
  );

  // p0 -> p1: output register; reset shows an all-zero accumulator with its flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result_p1 <= '0;
      r_zero_p1   <= 1'b1;
    end else begin
      r_result_p1 <= w_next_result_p0;
      r_zero_p1   <= w_next_zero_p0;
    end
  end

  assign result  = r_result_p1;
  assign is_zero = r_zero_p1;

endmodule

// File: tb/tb_risc_alu.sv
// Directed and random stimulus for risc_alu with a queue scoreboard and immediate assertions.
module tb_risc_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] inA;
  logic [7:0] inB;
  logic [2:0] opcode;
  logic [7:0] result;
  logic       is_zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] res;
    logic       z;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  risc_alu #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .inA     (inA),
    .inB     (inB),
    .opcode  (opcode),
    .result  (result),
    .is_zero (is_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    int s;
    if (op == 3'd2) begin
      s = (int'(a) + int'(b)) % 256;
      return s[7:0];
    end
    if (op == 3'd3) return a & b;
    if (op == 3'd4) return a ^ b;
    if (op == 3'd5) return b;
    return a;
  endfunction

  task automatic check_out(input string tag, input logic [7:0] er, input logic ez);
    checks++;
    assert (result === er) else begin
      failures++;
      $error("FAIL %s result got=%h exp=%h", tag, result, er);
    end
    checks++;
    assert (is_zero === ez) else begin
      failures++;
      $error("FAIL %s is_zero got=%b exp=%b", tag, is_zero, ez);
    end
  endtask

  task automatic step(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input string tag);
    exp_t e;
    logic [7:0] m;
    @(negedge clk);
    opcode = op;
    inA    = a;
    inB    = b;
    m      = model(op, a, b);
    e.res  = m;
    e.z    = (m == 8'h00);
    e.tag  = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (sb_q.size() != 0) else begin
      failures++;
      $error("FAIL %s scoreboard got=empty exp=entry", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_out(e.tag, e.res, e.z);
    end
  endtask

  initial begin
    rst    = 1'b1;
    inA    = 8'h55;
    inB    = 8'h00;
    opcode = 3'd0;
    #2;
    check_out("reset_init", 8'h00, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_out("reset_hold", 8'h00, 1'b1);

    step(3'd0, 8'h55, 8'h00, "hlt_55");

    // Asynchronous reset mid-cycle, then release and reload.
    #2;
    rst = 1'b1;
    #1;
    check_out("reset_async", 8'h00, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_out("reset_release_hold", 8'h00, 1'b1);
    step(3'd0, 8'h55, 8'h00, "hlt_after_reset");

    step(3'd0, 8'h00, 8'h12, "hlt_zero");
    step(3'd1, 8'h00, 8'h34, "skz_zero");
    step(3'd6, 8'h00, 8'h56, "sto_zero");
    step(3'd7, 8'h00, 8'h78, "jmp_zero");
    step(3'd1, 8'h01, 8'h01, "skz_one");
    step(3'd6, 8'd20, 8'h00, "sto_20");
    step(3'd7, 8'd25, 8'h00, "jmp_25");

    step(3'd2, 8'd5,  8'd10,  "add_5_10");
    step(3'd2, 8'h01, 8'hFF,  "add_wrap");
    step(3'd2, 8'h80, 8'h80,  "add_80_80");

    step(3'd3, 8'h05, 8'h03, "and_05_03");
    step(3'd3, 8'h04, 8'h03, "and_04_03");
    step(3'd4, 8'h05, 8'h03, "xor_05_03");
    step(3'd4, 8'hAA, 8'hAA, "xor_aa_aa");

    step(3'd5, 8'h00, 8'h0F, "lda_0f");
    step(3'd5, 8'hFF, 8'h00, "lda_zero");

    for (int i = 0; i < 200; i++) begin
      step(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
